// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store access unit: funct3 encodings,
// FSM states, and request legality checks.
package mem_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int OFFSET_BITS = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_funct3_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EXT,
    WR,
    RESP
  } mem_state_e;

  // Stores only support B/H/W; loads additionally support the unsigned forms.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic legal;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !is_store;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // f3[1:0] encodes the access size (00 byte, 01 half, 10 word).
  function automatic logic misaligned(input logic [1:0] size_code, input logic [1:0] offset);
    logic mis;
    case (size_code)
      2'b01:   mis = offset[0];
      2'b10:   mis = |offset;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit RAM word and the core: extracts and
// extends load lanes, and merges sub-word store data into the old word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  byte_lanes [WORD_BYTES];
  logic [15:0] half_lanes [2];

  // Little-endian: byte n lives at bits [8n+7:8n].
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
    assign byte_lanes[gi] = i_word[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_halves
    assign half_lanes[gi] = i_word[16*gi +: 16];
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = byte_lanes[i_offset];
  assign sel_half = half_lanes[i_offset[1]];

  always_comb begin
    o_load_data = i_word;
    case (i_funct3)
      MEM_B:   o_load_data = {{24{sel_byte[7]}}, sel_byte};
      MEM_BU:  o_load_data = {24'b0, sel_byte};
      MEM_H:   o_load_data = {{16{sel_half[15]}}, sel_half};
      MEM_HU:  o_load_data = {16'b0, sel_half};
      default: o_load_data = i_word;
    endcase
  end

  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      MEM_B: o_store_word[8*i_offset +: 8] = i_wdata[7:0];
      MEM_H: begin
        if (i_offset[1]) begin
          o_store_word[31:16] = i_wdata[15:0];
        end else begin
          o_store_word[15:0] = i_wdata[15:0];
        end
      end
      MEM_W:   o_store_word = i_wdata;
      default: o_store_word = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for a single-port read-first word RAM: serves RISC-V loads and
// stores one at a time, doing read-modify-write for byte and half stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [2:0]               i_req_funct3,
  input  logic [31:0]              i_req_addr,
  input  logic [31:0]              i_req_wdata,
  output logic                     o_rsp_valid,
  output logic [31:0]              o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic [31:0]              o_ram_data,
  output logic                     o_ram_we,
  input  logic [31:0]              i_ram_data
);

  localparam int AW = $clog2(DEPTH);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("mem_access_unit: DATA_WIDTH must be 32");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH > (1 << 29))) begin : g_bad_depth
    $error("mem_access_unit: DEPTH must be a power of two in [2, 2**29]");
  end

  mem_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      offset_q, offset_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]     ram_data_q, ram_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign o_req_ready = (state_q == IDLE) && i_rst_n;
  assign o_ram_we    = (state_q == WR) && i_rst_n;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_data  = ram_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

  assign accept  = i_req_valid && o_req_ready;
  assign req_err = !funct3_legal(i_req_we, i_req_funct3)
                || misaligned(i_req_funct3[1:0], i_req_addr[1:0])
                || (|i_req_addr[31:AW+OFFSET_BITS]);

  mem_lane_align u_align (
    .i_word       (i_ram_data),
    .i_offset     (offset_q),
    .i_funct3     (funct3_q),
    .i_wdata      (wdata_q),
    .o_load_data  (load_data),
    .o_store_word (store_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'b0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = i_req_we;
          funct3_d = i_req_funct3;
          offset_d = i_req_addr[1:0];
          wdata_d  = i_req_wdata;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            ram_addr_d = i_req_addr[AW+OFFSET_BITS-1:OFFSET_BITS];
            if (i_req_we && (i_req_funct3 == MEM_W)) begin
              state_d    = WR;
              ram_data_d = i_req_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD:  state_d = EXT;
      // The RAM is returning the old word addressed during RD.
      EXT: begin
        if (!we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end else begin
          state_d    = WR;
          ram_data_d = store_word;
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b0;
      offset_q    <= 2'b0;
      wdata_q     <= 32'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [2:0]    i_req_funct3;
  logic [31:0]   i_req_addr;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_data;
  logic          o_ram_we;
  logic [31:0]   i_ram_data;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_ram_addr   (o_ram_addr),
    .o_ram_data   (o_ram_data),
    .o_ram_we     (o_ram_we),
    .i_ram_data   (i_ram_data)
  );

  // Attached RAM: synchronous, read-first, no byte enables.
  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
    i_ram_data <= ram[o_ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    bit          has_lit;
    logic [31:0] lit_rdata;
    logic        lit_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decide the outcome of a request from the architectural
  // rules at the moment it is accepted in cycle c.
  task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input bit has_lit,
                              input logic [31:0] lit_rdata, input logic lit_err, input int c);
    exp_t        e;
    int          size;
    bit          legal;
    int          idx;
    int          off;
    logic [31:0] word;
    logic [31:0] lane;
    logic [31:0] mask;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e.we = we; e.f3 = f3; e.addr = addr;
    e.rdata = 32'd0; e.wr = 1'b0; e.waddr = 32'd0; e.wdata = 32'd0;
    e.has_lit = has_lit; e.lit_rdata = lit_rdata; e.lit_err = lit_err;
    e.err = !legal || (addr >= 32'(DEPTH * 4)) || ((addr % 32'(size)) != 0);
    if (e.err) begin
      e.due = c + 1;
    end else begin
      idx  = int'(addr / 4);
      off  = int'(addr % 4);
      word = ref_mem[idx];
      lane = word >> (8 * off);
      if (!we) begin
        e.due = c + 3;
        case (f3)
          3'd0:    e.rdata = (lane[7:0] >= 8'd128) ? (32'(lane[7:0]) - 32'd256) : 32'(lane[7:0]);
          3'd4:    e.rdata = 32'(lane[7:0]);
          3'd1:    e.rdata = (lane[15:0] >= 16'h8000) ? (32'(lane[15:0]) - 32'h10000) : 32'(lane[15:0]);
          3'd5:    e.rdata = 32'(lane[15:0]);
          default: e.rdata = word;
        endcase
      end else begin
        e.wr    = 1'b1;
        e.waddr = 32'(idx);
        if (f3 == 3'd2) begin
          e.due   = c + 2;
          e.wdata = wd;
        end else begin
          e.due   = c + 4;
          mask    = (size == 1) ? 32'hFF : 32'hFFFF;
          e.wdata = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        end
        ref_mem[idx] = e.wdata;
      end
    end
    exp_q.push_back(e);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(o_req_ready), 32'd0);
        chk("reset_ram_we",    32'(o_ram_we),    32'd0);
        chk("reset_rsp_rdata", o_rsp_rdata,      32'd0);
        chk("reset_rsp_err",   32'(o_rsp_err),   32'd0);
        chk("reset_ram_addr",  32'(o_ram_addr),  32'd0);
        chk("reset_ram_data",  o_ram_data,       32'd0);
      end else begin
        bit have;
        bit exp_we;
        bit exp_valid;
        have      = exp_q.size() > 0;
        exp_we    = have && exp_q[0].wr && (exp_q[0].due - 1 == cyc);
        exp_valid = have && (exp_q[0].due == cyc);
        chk("req_ready", 32'(o_req_ready), 32'(!have));
        chk("ram_we",    32'(o_ram_we),    32'(exp_we));
        if (exp_we) begin
          chk("ram_addr", 32'(o_ram_addr), exp_q[0].waddr);
          chk("ram_data", o_ram_data,      exp_q[0].wdata);
        end
        chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
          chk("rsp_rdata", o_rsp_rdata,    exp_q[0].rdata);
          chk("rsp_err",   32'(o_rsp_err), 32'(exp_q[0].err));
          if (exp_q[0].has_lit) begin
            chk("lit_rdata", o_rsp_rdata,    exp_q[0].lit_rdata);
            chk("lit_err",   32'(o_rsp_err), 32'(exp_q[0].lit_err));
          end
          n_txn++;
          $display("txn %0d: we=%0d f3=%0d addr=%h -> rdata=%h err=%0d (cycle %0d)",
                   n_txn, exp_q[0].we, exp_q[0].f3, exp_q[0].addr, o_rsp_rdata, o_rsp_err, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present a request at a falling edge and wait (bounded) until it is taken.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit has_lit,
                       input logic [31:0] lit_rdata, input logic lit_err);
    int waits = 0;
    @(negedge clk);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    while (!o_req_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    n_checks++;
    if (!o_req_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: ready=%0d after %0d cycles, required 1", o_req_ready, waits);
    end else begin
      model_accept(we, f3, addr, wd, has_lit, lit_rdata, lit_err, cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    i_req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] saved;
    int          w;
    rst_n        = 1'b0;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'd0;
    i_req_wdata  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      v          = $urandom;
      ram[i]    <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // SW then LW
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    drain();
    chk("ram_w4_sw", ram[4], 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    drain();

    // Byte/half loads
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0); drain();
    issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b1, 32'h000000DE, 1'b0); drain();
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0); drain();
    issue(1'b0, 3'd5, 32'h10, 32'h0, 1'b1, 32'h0000BEEF, 1'b0); drain();

    // Sub-word read-modify-write
    issue(1'b1, 3'd0, 32'h11, 32'h55, 1'b1, 32'h0, 1'b0);
    drain();
    chk("ram_w4_sb", ram[4], 32'hDEAD55EF);
    issue(1'b1, 3'd1, 32'h12, 32'h1234, 1'b1, 32'h0, 1'b0);
    drain();
    chk("ram_w4_sh", ram[4], 32'h123455EF);

    // Error cases
    issue(1'b0, 3'd2, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1); drain();
    issue(1'b1, 3'd1, 32'h13, 32'hFFFF, 1'b1, 32'h0, 1'b1); drain();
    issue(1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 1'b1, 32'h0, 1'b1); drain();
    issue(1'b1, 3'd4, 32'h10, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b1); drain();
    chk("ram_w4_after_err", ram[4], 32'h123455EF);

    // Reset during the write cycle of an SB
    saved = ref_mem[4];
    issue(1'b1, 3'd0, 32'h10, 32'hAA, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    i_req_valid = 1'b0;
    w = 0;
    while (!o_ram_we && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("abort_saw_wr", 32'(o_ram_we), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    ref_mem[4] = saved;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after_reset", 32'(o_req_ready), 32'd1);
    chk("abort_ram_w4", ram[4], 32'h123455EF);

    // Back-to-back with valid held high
    issue(1'b1, 3'd2, 32'h14, 32'h01020304, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h14, 32'h0,        1'b1, 32'h01020304, 1'b0);
    issue(1'b1, 3'd0, 32'h15, 32'h000000F0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd0, 32'h15, 32'h0,        1'b1, 32'hFFFFFFF0, 1'b0);
    issue(1'b0, 3'd2, 32'h16, 32'h0,        1'b1, 32'h0, 1'b1);
    issue(1'b1, 3'd1, 32'h16, 32'hBEEF,     1'b0, 32'h0, 1'b0);
    issue(1'b0, 3'd5, 32'h16, 32'h0,        1'b1, 32'h0000BEEF, 1'b0);
    issue(1'b0, 3'd2, 32'h14, 32'h0,        1'b1, 32'hBEEFF004, 1'b0);
    drain();

    // Random traffic over a small window so words are reused
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          size;
      int          r;
      we   = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 9));
      f3   = (r < 8) ? 3'(($urandom_range(0, 4) == 0) ? 2 : $urandom_range(0, 5)) : 3'($urandom_range(0, 7));
      size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) addr = addr & ~32'(size - 1);
      r = int'($urandom_range(0, 19));
      if (r == 0) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
      else if (r == 1) addr = $urandom;
      issue(we, f3, addr, $urandom, 1'b0, 32'h0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    idle(2);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("final_ram_w%0d", i), ram[i], ref_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
